uart_tx_scheduler: RTL
======================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter STOP_BITS, default 1, giving the number of stop bits per frame (legal values 1 or 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the 50 MHz system clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 4 bits: per-requester level request to send one byte.
REQ-005 The block SHALL have port req_data, input, 32 bits: byte for requester i on bits [8i+7:8i].
REQ-006 The block SHALL have port ack, output, 4 bits: one-cycle pulse to requester i when its byte is accepted.
REQ-007 The block SHALL have port bps_start, output, 1 bit: enable for the shared baud generator.
REQ-008 The block SHALL have port clk_bps, input, 1 bit: one-cycle baud tick from the baud generator, valid only while bps_start is high.
REQ-009 The block SHALL have port uart_tx, output, 1 bit: serial line, idle high.
REQ-010 The block SHALL have port busy, output, 1 bit: high from grant until the end of the last stop bit.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY SHALL be reachable only when PARITY_EN is defined.
REQ-012 In IDLE with req != 0, the block SHALL grant the first asserted requester at or after pointer rr_ptr, searching upward with wrap-around 3->0.
REQ-013 On the grant cycle, the block SHALL pulse ack[i] for exactly one cycle and latch req_data[8i+7:8i].
REQ-014 On the grant cycle, the block SHALL set rr_ptr to (i+1) mod 4.
REQ-015 On the grant cycle, the block SHALL set busy and bps_start on the following clock edge and enter START.
REQ-016 In START, on the first clk_bps pulse the block SHALL drive uart_tx low and enter DATA.
REQ-017 In DATA, each clk_bps pulse SHALL drive the next data bit, LSB first.
REQ-018 The block SHALL hold a 3-bit bit counter that wraps 7->0.
REQ-019 On the clk_bps that presents bit 7, the block SHALL leave DATA for PARITY if PARITY_EN is defined, else for STOP.
REQ-020 The block SHALL advance uart_tx, state and counters only on cycles where clk_bps is high; all other cycles SHALL hold state.
REQ-021 STOP SHALL drive uart_tx high for STOP_BITS clk_bps intervals; on the clk_bps pulse ending the last stop bit, the block SHALL clear bps_start and busy and return to IDLE.
REQ-022 A new grant SHALL be possible on the cycle after the return to IDLE; the block SHALL not release the line mid-frame.
REQ-023 A requester that deasserts req before its ack SHALL not be served, and no ack SHALL be issued to it.
REQ-024 req and req_data changes after ack SHALL not affect the frame in flight.
REQ-025 clk_bps pulses received while in IDLE SHALL be ignored.
REQ-026 ack SHALL be one-hot or zero at all times.

Reset
REQ-027 While rst_n is low, the block SHALL hold uart_tx=1, bps_start=0, busy=0, ack=0, rr_ptr=0, bit counter=0, and state IDLE.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, with uart_tx high asynchronously.
REQ-029 After reset the block SHALL issue no ack for an aborted request; the requester's still-asserted req SHALL be re-arbitrated normally.

Configuration
REQ-030 With macro UART_PARITY_EN defined, the block SHALL insert one even-parity bit, XOR of the 8 data bits, between bit 7 and the first stop bit, making the frame 11 + (STOP_BITS-1) bits.
REQ-031 With UART_PARITY_EN undefined, the block SHALL have no PARITY state or parity logic, and the frame SHALL be 10 + (STOP_BITS-1) bits.

Verification
REQ-032 The bench SHALL drive req=0001, byte 0xA5, no parity -> one ack[0] pulse; uart_tx per clk_bps = 0,1,0,1,0,0,1,0,1,1; then busy=0.
REQ-033 The bench SHALL drive req=1111 held, bytes 0x11/0x22/0x33/0x44 -> frames in order 0x11,0x22,0x33,0x44 with one ack each; then rr_ptr=0.
REQ-034 The bench SHALL set rr_ptr=2 (after serving req 1) and drive req=0011 -> requester 0 served before requester 1.
REQ-035 The bench SHALL build with UART_PARITY_EN and send 0x07 -> parity bit 1, frame 0,1,1,1,0,0,0,0,0,1,1.
REQ-036 The bench SHALL assert rst_n low after 4 data bits -> same-cycle uart_tx=1, bps_start=0, busy=0; after release a held req gets a full new frame.
REQ-037 The bench SHALL set STOP_BITS=2, send back-to-back bytes, and inject clk_bps in IDLE -> two high stop intervals between frames; the IDLE ticks are ignored.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that serves four byte requesters over one UART transmit line.
// Define UART_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bits.
module uart_tx_scheduler #(
   parameter int STOP_BITS = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req,
   input  logic [31:0] req_data,
   output logic [3:0]  ack,
   output logic        bps_start,
   input  logic        clk_bps,
   output logic        uart_tx,
   output logic        busy,
   output logic [2:0]  dbg_state,
   output logic [1:0]  dbg_rr_ptr,
   output logic [2:0]  dbg_bit_cnt
);

   // Handshake: req[i] is a level held until ack[i]; ack[i] pulses for one cycle right after the
   // edge that latched byte i, so later req/req_data changes cannot touch the frame in flight.
   // clk_bps is only acted on while bps_start is high; every other cycle holds all state.

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   localparam logic [2:0] STOP_LAST = 3'(STOP_BITS);

   state_t     state_q, state_d;
   logic [1:0] rr_ptr_q, rr_ptr_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] data_q, data_d;
   logic       tx_q, tx_d;
   logic [3:0] ack_q, ack_d;
   logic       grant_vld;
   logic [1:0] grant_idx;
   logic [1:0] probe;

   // Scan downward so the requester closest to rr_ptr is the last, winning, assignment.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = rr_ptr_q;
      probe     = '0;
      for (int k = 3; k >= 0; k--) begin
         probe = rr_ptr_q + 2'(k);
         if (req[probe]) begin
            grant_vld = 1'b1;
            grant_idx = probe;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      bit_cnt_d = bit_cnt_q;
      data_d    = data_q;
      tx_d      = tx_q;
      ack_d     = '0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (grant_vld) begin
               ack_d[grant_idx] = 1'b1;
               data_d           = req_data[{grant_idx, 3'b000} +: 8];
               rr_ptr_d         = grant_idx + 2'd1;
               bit_cnt_d        = 3'd0;
               state_d          = START;
            end
         end
         START: begin
            if (clk_bps) begin
               tx_d    = 1'b0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (clk_bps) begin
               tx_d      = data_q[bit_cnt_q];
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_PARITY_EN
         PARITY: begin
            if (clk_bps) begin
               tx_d    = ^data_q;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            // The first tick raises the line; STOP_BITS further ticks close the stop intervals.
            if (clk_bps) begin
               tx_d = 1'b1;
               if (bit_cnt_q == STOP_LAST) begin
                  bit_cnt_d = 3'd0;
                  state_d   = IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_ptr_q  <= 2'd0;
         bit_cnt_q <= 3'd0;
         data_q    <= 8'd0;
         tx_q      <= 1'b1;
         ack_q     <= 4'd0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         bit_cnt_q <= bit_cnt_d;
         data_q    <= data_d;
         tx_q      <= tx_d;
         ack_q     <= ack_d;
      end
   end

   assign ack         = ack_q;
   assign uart_tx     = tx_q;
   assign busy        = (state_q != IDLE);
   assign bps_start   = (state_q != IDLE);
   assign dbg_state   = state_q;
   assign dbg_rr_ptr  = rr_ptr_q;
   assign dbg_bit_cnt = bit_cnt_q;

endmodule
